// File: rtl/turbo_st_arb.sv
// Packet-granular round-robin arbiter: shares one TurboDecoder Avalon-ST input among N_CH
// bus2st channels, tagging beats with the source channel and policing length and stalls.
module turbo_st_arb #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned w_CH    = 2,
  parameter int unsigned ST      = 24,
  parameter int unsigned w_LEN   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       ch_req,
  input  logic [N_CH*ST-1:0]    ch_st_data,
  input  logic [N_CH-1:0]       ch_st_valid,
  input  logic [N_CH-1:0]       ch_st_sop,
  input  logic [N_CH-1:0]       ch_st_eop,
  input  logic [N_CH*w_LEN-1:0] ch_st_len,
  output logic [N_CH-1:0]       ch_st_ready,
  output logic [N_CH-1:0]       ch_abort,
  input  logic                  dec_st_ready,
  output logic [ST-1:0]         dec_st_data,
  output logic                  dec_st_valid,
  output logic                  dec_st_sop,
  output logic                  dec_st_eop,
  output logic [w_LEN-1:0]      dec_st_len,
  output logic [w_CH-1:0]       dec_ch_id,
  output logic                  busy,
  output logic                  err_len,
  output logic                  err_tmo,
  output logic [w_CH-1:0]       err_ch,
  input  logic                  err_clr
);

  localparam int unsigned IdleW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer} state_e;

  state_e            state_q, state_d;
  logic [w_CH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [w_CH-1:0]   g_q, g_d;
  logic [w_LEN-1:0]  len_q, len_d;
  logic [w_LEN-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [ST-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [w_LEN-1:0]  dlen_q, dlen_d;
  logic [w_CH-1:0]   id_q, id_d;
  logic              err_len_q, err_len_d;
  logic              err_tmo_q, err_tmo_d;
  logic [w_CH-1:0]   err_ch_q, err_ch_d;

  logic              found;
  logic [w_CH-1:0]   pick, arb_idx;
  logic              sel_valid, sel_sop, sel_eop;
  logic [ST-1:0]     sel_data;
  logic              accept, tmo, len_bad;

  assign sel_valid = ch_st_valid[g_q];
  assign sel_sop   = ch_st_sop[g_q];
  assign sel_eop   = ch_st_eop[g_q];
  assign sel_data  = ch_st_data[g_q*ST +: ST];

  assign accept  = (state_q == StXfer) && sel_valid && dec_st_ready;
  assign tmo     = (state_q == StXfer) && !accept && (idle_cnt_q == IdleW'(TIMEOUT - 1));
  assign len_bad = accept && sel_eop && ((beat_cnt_q + w_LEN'(1)) != len_q);

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      arb_idx = w_CH'((rr_ptr_q + k) % N_CH);
      if (!found && ch_req[arb_idx]) begin
        found = 1'b1;
        pick  = arb_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (found) state_d = StGrant;
      StGrant: state_d = StXfer;
      StXfer:  if ((accept && sel_eop) || tmo) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q == StGrant) || (state_q == StXfer);
    ch_st_ready = '0;
    ch_abort    = '0;
    if (state_q == StXfer) ch_st_ready[g_q] = dec_st_ready;
    if (tmo)               ch_abort[g_q]    = 1'b1;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    g_d        = g_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = accept;
    sop_d      = sop_q;
    eop_d      = eop_q;
    dlen_d     = dlen_q;
    id_d       = id_q;
    err_len_d  = err_len_q;
    err_tmo_d  = err_tmo_q;
    err_ch_d   = err_ch_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          g_d      = pick;
          len_d    = ch_st_len[pick*w_LEN +: w_LEN];
          rr_ptr_d = pick;
        end
      end
      StGrant: begin
        id_d       = g_q;
        dlen_d     = len_q;
        beat_cnt_d = '0;
        idle_cnt_d = '0;
      end
      StXfer: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + w_LEN'(1);
          idle_cnt_d = '0;
          data_d     = sel_data;
          sop_d      = sel_sop;
          eop_d      = sel_eop;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
      end
      default: ;
    endcase
    // A new error in the same cycle as err_clr must survive the clear.
    if (err_clr) begin
      err_len_d = 1'b0;
      err_tmo_d = 1'b0;
      err_ch_d  = '0;
    end
    if (len_bad) begin
      err_len_d = 1'b1;
      err_ch_d  = g_q;
    end
    if (tmo) begin
      err_tmo_d = 1'b1;
      err_ch_d  = g_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= w_CH'(N_CH - 1);
      g_q        <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dlen_q     <= '0;
      id_q       <= '0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_ch_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      g_q        <= g_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      dlen_q     <= dlen_d;
      id_q       <= id_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
      err_ch_q   <= err_ch_d;
    end
  end

  assign dec_st_data  = data_q;
  assign dec_st_valid = valid_q;
  assign dec_st_sop   = sop_q;
  assign dec_st_eop   = eop_q;
  assign dec_st_len   = dlen_q;
  assign dec_ch_id    = id_q;
  assign err_len      = err_len_q;
  assign err_tmo      = err_tmo_q;
  assign err_ch       = err_ch_q;

endmodule

// File: tb/tb_turbo_st_arb.sv
// Directed bench for turbo_st_arb: per-channel frame sources, output beat log, immediate
// assertions against hand-derived beat order, timing and error flags.
module tb_turbo_st_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_req, ch_st_valid, ch_st_sop, ch_st_eop;
  logic [95:0] ch_st_data;
  logic [63:0] ch_st_len;
  logic [3:0]  ch_st_ready, ch_abort;
  logic        dec_st_ready;
  logic [23:0] dec_st_data;
  logic        dec_st_valid, dec_st_sop, dec_st_eop;
  logic [15:0] dec_st_len;
  logic [1:0]  dec_ch_id;
  logic        busy, err_len, err_tmo;
  logic [1:0]  err_ch;
  logic        err_clr;

  turbo_st_arb #(
    .N_CH(4), .w_CH(2), .ST(24), .w_LEN(16), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req(ch_req), .ch_st_data(ch_st_data), .ch_st_valid(ch_st_valid),
    .ch_st_sop(ch_st_sop), .ch_st_eop(ch_st_eop), .ch_st_len(ch_st_len),
    .ch_st_ready(ch_st_ready), .ch_abort(ch_abort),
    .dec_st_ready(dec_st_ready), .dec_st_data(dec_st_data), .dec_st_valid(dec_st_valid),
    .dec_st_sop(dec_st_sop), .dec_st_eop(dec_st_eop), .dec_st_len(dec_st_len),
    .dec_ch_id(dec_ch_id), .busy(busy), .err_len(err_len), .err_tmo(err_tmo),
    .err_ch(err_ch), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Source model state per channel.
  int frames[4], nbeats[4], lenv[4], idx[4], fr[4];
  bit stall[4];
  bit tog = 1'b0;
  bit clr_on_eop = 1'b0;
  int clr_ch = 0;
  int stop_at = -1;

  // Output log.
  logic [23:0] m_data[$];
  bit          m_sop[$], m_eop[$], m_rdy[$];
  int          m_id[$], m_cyc[$];
  int          ab_cyc[$];
  logic [3:0]  ab_vec[$];
  int          multi_rdy = 0;
  logic        prev_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dec_st_valid === 1'b1) begin
      m_data.push_back(dec_st_data);
      m_sop.push_back(dec_st_sop);
      m_eop.push_back(dec_st_eop);
      m_id.push_back(int'(dec_ch_id));
      m_cyc.push_back(cyc);
      m_rdy.push_back(prev_rdy);
    end
    if ($countones(ch_st_ready) > 1) multi_rdy <= multi_rdy + 1;
    if (ch_abort != 4'b0000) begin
      ab_cyc.push_back(cyc);
      ab_vec.push_back(ch_abort);
    end
    prev_rdy <= dec_st_ready;
  end

  function automatic logic [23:0] mk(input int c, input int f, input int b);
    return {c[7:0], f[7:0], b[7:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    m_data.delete(); m_sop.delete(); m_eop.delete(); m_rdy.delete();
    m_id.delete(); m_cyc.delete();
  endtask

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      ch_req[c]                = frames[c] > 0;
      ch_st_valid[c]           = (frames[c] > 0) && !stall[c];
      ch_st_data[c*24 +: 24]   = mk(c, fr[c], idx[c]);
      ch_st_sop[c]             = idx[c] == 0;
      ch_st_eop[c]             = idx[c] == nbeats[c] - 1;
      ch_st_len[c*16 +: 16]    = lenv[c][15:0];
    end
  endtask

  task automatic prog(input int c, input int nf, input int nb, input int ln);
    frames[c] = nf; nbeats[c] = nb; lenv[c] = ln; idx[c] = 0; fr[c] = 0;
  endtask

  // Runs the sources until all frames are done and the arbiter is idle (or stop_at is hit).
  task automatic run(input int max_cyc);
    int n;
    bit done;
    bit acc[4];
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        acc[c] = ch_st_ready[c] & ch_st_valid[c];
        if (ch_abort[c]) begin frames[c] = 0; idx[c] = 0; end
      end
      if (clr_on_eop && acc[clr_ch] && ch_st_eop[clr_ch]) err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) begin
          idx[c]++;
          if (idx[c] == nbeats[c]) begin idx[c] = 0; frames[c]--; fr[c]++; end
        end
      end
      if (tog) dec_st_ready = ~dec_st_ready;
      drive();
      n++;
      if (stop_at >= 0) done = (idx[0] == stop_at);
      else done = (frames[0] + frames[1] + frames[2] + frames[3] == 0) && !busy;
    end
    check("run_bound", done, 1);
    if (stop_at < 0) repeat (2) begin @(posedge clk); #1; end
  endtask

  int c0;
  int ord[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int c = 0; c < 4; c++) begin prog(c, 0, 1, 1); stall[c] = 1'b0; end
    ch_req = '0; ch_st_valid = '0; ch_st_sop = '0; ch_st_eop = '0;
    ch_st_data = '0; ch_st_len = '0;
    dec_st_ready = 1'b1; err_clr = 1'b0;
    drive();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", dec_st_valid, 0);
    check("rst_ready", ch_st_ready, 0);
    check("rst_abort", ch_abort, 0);
    check("rst_busy", busy, 0);
    check("rst_err", {err_len, err_tmo, err_ch}, 0);
    check("rst_id_len", {dec_ch_id, dec_st_len}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame on ch0, len 5, continuous ready.
    clear_mon();
    prog(0, 1, 5, 5); drive();
    c0 = cyc;
    run(60);
    check("t1_cnt", m_data.size(), 5);
    for (int i = 0; i < m_data.size() && i < 5; i++) begin
      check($sformatf("t1_data%0d", i), m_data[i], mk(0, 0, i));
      check($sformatf("t1_cyc%0d", i), m_cyc[i] - c0, 3 + i);
      check($sformatf("t1_sop%0d", i), m_sop[i], i == 0);
      check($sformatf("t1_eop%0d", i), m_eop[i], i == 4);
      check($sformatf("t1_id%0d", i), m_id[i], 0);
    end
    check("t1_len", dec_st_len, 5);
    check("t1_err", {err_len, err_tmo}, 0);

    // Backpressure: ready toggles every cycle during an 8-beat frame on ch3.
    clear_mon();
    prog(3, 1, 8, 8); drive();
    tog = 1'b1;
    run(80);
    tog = 1'b0; dec_st_ready = 1'b1;
    check("bp_cnt", m_data.size(), 8);
    for (int i = 0; i < m_data.size() && i < 8; i++) begin
      check($sformatf("bp_data%0d", i), m_data[i], mk(3, 0, i));
      check($sformatf("bp_rdy%0d", i), m_rdy[i], 1);
      if (i > 0) check($sformatf("bp_gap%0d", i), m_cyc[i] - m_cyc[i-1], 2);
    end

    // Fairness: all four request; ch0 has a second frame queued.
    clear_mon();
    multi_rdy = 0;
    prog(0, 2, 3, 3); prog(1, 1, 3, 3); prog(2, 1, 3, 3); prog(3, 1, 3, 3); drive();
    run(200);
    check("fair_cnt", m_data.size(), 15);
    for (int k = 0; k < m_data.size() && k < 15; k++) begin
      check($sformatf("fair_id%0d", k), m_id[k], ord[k/3]);
      check($sformatf("fair_data%0d", k), m_data[k], mk(ord[k/3], (k/3 == 4) ? 1 : 0, k % 3));
      if (k % 3 != 0) check($sformatf("fair_gap%0d", k), m_cyc[k] - m_cyc[k-1], 1);
      else if (k > 0) check($sformatf("fair_gap%0d", k), m_cyc[k] - m_cyc[k-1], 3);
    end
    check("fair_onehot", multi_rdy, 0);

    // Length error on ch2 (len 6, eop on beat 4) with err_clr in the same cycle.
    clear_mon();
    prog(2, 1, 4, 6); drive();
    clr_on_eop = 1'b1; clr_ch = 2;
    run(60);
    clr_on_eop = 1'b0;
    check("le_cnt", m_data.size(), 4);
    check("le_err_len", err_len, 1);
    check("le_err_ch", err_ch, 2);
    check("le_err_tmo", err_tmo, 0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("le_clr", {err_len, err_tmo, err_ch}, 0);
    clear_mon();
    prog(2, 1, 3, 3); drive();
    run(60);
    check("le_good_cnt", m_data.size(), 3);
    check("le_good_err", {err_len, err_ch}, 0);

    // Watchdog: ch1 granted but never valid.
    clear_mon();
    ab_cyc.delete(); ab_vec.delete();
    stall[1] = 1'b1;
    prog(1, 1, 4, 4); drive();
    c0 = cyc;
    run(100);
    stall[1] = 1'b0;
    check("wd_abort_cnt", ab_cyc.size(), 1);
    if (ab_cyc.size() > 0) begin
      check("wd_abort_cyc", ab_cyc[0] - c0, 17);
      check("wd_abort_vec", ab_vec[0], 4'b0010);
    end
    check("wd_err_tmo", err_tmo, 1);
    check("wd_err_ch", err_ch, 1);
    check("wd_err_len", err_len, 0);
    check("wd_no_beats", m_data.size(), 0);
    prog(3, 1, 2, 2); drive();
    run(60);
    check("wd_next_cnt", m_data.size(), 2);
    if (m_data.size() > 0) check("wd_next_id", m_id[0], 3);
    check("wd_abort_once", ab_cyc.size(), 1);

    // Reset while beat 3 of 10 is presented on ch0.
    clear_mon();
    prog(0, 1, 10, 10); drive();
    stop_at = 2;
    run(60);
    stop_at = -1;
    rst_n = 1'b0;
    #1;
    check("mr_valid", dec_st_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_ready", ch_st_ready, 0);
    check("mr_id_len", {dec_ch_id, dec_st_len}, 0);
    check("mr_data", dec_st_data, 0);
    check("mr_err", {err_len, err_tmo, err_ch}, 0);
    prog(0, 0, 1, 1); drive();
    clear_mon();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mr_silent", m_data.size(), 0);
    prog(0, 1, 2, 2); prog(1, 1, 2, 2); drive();
    run(60);
    check("mr_cnt", m_data.size(), 4);
    if (m_data.size() == 4) begin
      check("mr_first_id", m_id[0], 0);
      check("mr_second_id", m_id[2], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
